// File: rtl/alu_pkg.sv
// Shared constants and types for the EX-stage ALU and the iterative mul/div sequencer.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_DIVU = 2'b01;
    localparam logic [1:0] MD_REMU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One shift-add (MUL) or restoring-division (DIVU/REMU) iteration around the borrowed ALU.
module muldiv_step
    import alu_pkg::*;
(
    input  logic [1:0]  i_op,
    input  logic [31:0] i_acc,
    input  logic [31:0] i_mcand,
    input  logic [31:0] i_mplier,
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_alu_result,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [2:0]  o_alu_op,
    output logic [31:0] o_acc_nxt,
    output logic [31:0] o_mcand_nxt,
    output logic [31:0] o_mplier_nxt,
    output logic [31:0] o_rem_nxt,
    output logic [31:0] o_quo_nxt
);

    logic        w_is_mul;
    logic [31:0] w_rs;
    logic        w_top;
    logic        w_borrow;
    logic        w_ok;

    // For division the mcand register carries the divisor, which never shifts.
    always_comb begin
        w_is_mul = (i_op == MD_MUL);
        w_rs     = {i_rem[30:0], i_quo[31]};
        w_top    = i_rem[31];
        w_borrow = (~w_rs[31] & i_mcand[31]) |
                   (~(w_rs[31] ^ i_mcand[31]) & i_alu_result[31]);
        w_ok     = w_top | ~w_borrow;

        o_alu_a      = w_is_mul ? i_acc : w_rs;
        o_alu_b      = w_is_mul ? (i_mplier[0] ? i_mcand : 32'd0) : i_mcand;
        o_alu_op     = w_is_mul ? ALU_ADD : ALU_SUB;

        o_acc_nxt    = i_alu_result;
        o_mcand_nxt  = i_mcand << 1;
        o_mplier_nxt = i_mplier >> 1;
        o_rem_nxt    = w_ok ? i_alu_result : w_rs;
        o_quo_nxt    = {i_quo[30:0], w_ok};
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative MUL/DIVU/REMU sequencer that borrows the shared EX-stage ALU one granted cycle at a time.
//   state  | meaning
//   S_IDLE | waiting for a request, req_ready high
//   S_RUN  | iterating, requests ALU each cycle, commits on grant
//   S_DONE | result held on rsp_data until consumer handshake
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            alu_req,
    input  logic            alu_grant,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [2:0]      alu_op,
    input  logic [31:0]     alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    state_t           r_state;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_acc;
    logic [31:0]      r_mcand;
    logic [31:0]      r_mplier;
    logic [31:0]      r_rem;
    logic [31:0]      r_quo;
    logic [31:0]      r_rsp_data;

    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [2:0]  w_alu_op;
    logic [31:0] w_acc_nxt;
    logic [31:0] w_mcand_nxt;
    logic [31:0] w_mplier_nxt;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic        w_run;

    muldiv_step u_step (
        .i_op         (r_op),
        .i_acc        (r_acc),
        .i_mcand      (r_mcand),
        .i_mplier     (r_mplier),
        .i_rem        (r_rem),
        .i_quo        (r_quo),
        .i_alu_result (alu_result),
        .o_alu_a      (w_alu_a),
        .o_alu_b      (w_alu_b),
        .o_alu_op     (w_alu_op),
        .o_acc_nxt    (w_acc_nxt),
        .o_mcand_nxt  (w_mcand_nxt),
        .o_mplier_nxt (w_mplier_nxt),
        .o_rem_nxt    (w_rem_nxt),
        .o_quo_nxt    (w_quo_nxt)
    );

    assign w_run     = (r_state == S_RUN);
    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign alu_req   = w_run;
    assign alu_a     = w_run ? w_alu_a  : 32'd0;
    assign alu_b     = w_run ? w_alu_b  : 32'd0;
    assign alu_op    = w_run ? w_alu_op : ALU_ADD;
    assign rsp_data  = r_rsp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= 2'b00;
            r_cnt      <= '0;
            r_acc      <= 32'd0;
            r_mcand    <= 32'd0;
            r_mplier   <= 32'd0;
            r_rem      <= 32'd0;
            r_quo      <= 32'd0;
            r_rsp_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op     <= req_op;
                        r_cnt    <= '0;
                        r_acc    <= 32'd0;
                        r_mcand  <= req_b;
                        r_mplier <= req_b;
                        r_rem    <= 32'd0;
                        r_quo    <= req_a;
                        case (req_op)
                            MD_MUL: begin
                                r_mcand <= req_a;
                                r_state <= S_RUN;
                            end
                            MD_DIVU, MD_REMU: begin
                                // Divide by zero resolves immediately without touching the ALU.
                                if (req_b == 32'd0) begin
                                    r_rsp_data <= (req_op == MD_DIVU) ? 32'hFFFF_FFFF : req_a;
                                    r_state    <= S_DONE;
                                end else begin
                                    r_state <= S_RUN;
                                end
                            end
                            default: begin
                                r_rsp_data <= 32'd0;
                                r_state    <= S_DONE;
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    if (alu_grant) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_op == MD_MUL) begin
                            r_acc    <= w_acc_nxt;
                            r_mcand  <= w_mcand_nxt;
                            r_mplier <= w_mplier_nxt;
                        end else begin
                            r_rem <= w_rem_nxt;
                            r_quo <= w_quo_nxt;
                        end
                        if (r_cnt == CNT_LAST) begin
                            case (r_op)
                                MD_MUL:  r_rsp_data <= w_acc_nxt;
                                MD_DIVU: r_rsp_data <= w_quo_nxt;
                                default: r_rsp_data <= w_rem_nxt;
                            endcase
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq with a behavioural shared ALU.
module tb_alu_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        alu_req;
    logic        alu_grant;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    int total;
    int bad;

    alu_muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_req    (alu_req),
        .alu_grant  (alu_grant),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign alu_result = (alu_op == 3'b001) ? (alu_a - alu_b) : (alu_a + alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit rnd, input bit hold,
                          output logic [31:0] data, output int lat, output int grants,
                          output int runcyc, output bit saw_req, output bit opbad,
                          output bit unstable);
        logic [2:0]  exp_aluop;
        logic [31:0] pa, pb;
        bit          prev_wait;
        bit          done;
        exp_aluop = (op == 2'b00) ? 3'b000 : 3'b001;
        data = 32'd0; lat = 0; grants = 0; runcyc = 0;
        saw_req = 0; opbad = 0; unstable = 0; prev_wait = 0; done = 0;
        pa = 32'd0; pb = 32'd0;
        @(negedge clk);
        chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        rsp_ready = hold ? 1'b0 : 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                data = rsp_data;
                done = 1;
            end else begin
                alu_grant = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (alu_req) begin
                    saw_req = 1;
                    runcyc++;
                    if (alu_grant) grants++;
                    if (alu_op !== exp_aluop) opbad = 1;
                    if (prev_wait && (alu_a !== pa || alu_b !== pb)) unstable = 1;
                    prev_wait = !alu_grant;
                    pa = alu_a; pb = alu_b;
                end
            end
        end
        alu_grant = 1'b1;
        if (!done) chk("rsp_valid_timeout", 32'd0, 32'd1);
        if (done && !hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_after_handshake", {30'd0, req_ready, rsp_valid}, 32'd2);
        end
    endtask

    logic [31:0] data;
    int          lat, grants, runcyc;
    bit          saw_req, opbad, unstable;
    int          cnt10;

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = 32'd0; req_b = 32'd0;
        alu_grant = 1'b1; rsp_ready = 1'b1;

        vecs[0]  = '{"mul_7x6",        2'b00, 32'd7,          32'd6,          32'd42,         33};
        vecs[1]  = '{"mul_ffxff",      2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          33};
        vecs[2]  = '{"mul_ovf",        2'b00, 32'h0001_0000,  32'h0001_0000,  32'd0,          33};
        vecs[3]  = '{"divu_100_7",     2'b01, 32'd100,        32'd7,          32'd14,         33};
        vecs[4]  = '{"remu_100_7",     2'b10, 32'd100,        32'd7,          32'd2,          33};
        vecs[5]  = '{"divu_top",       2'b01, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          33};
        vecs[6]  = '{"remu_top",       2'b10, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  33};
        vecs[7]  = '{"divu_small",     2'b01, 32'd5,          32'd10,         32'd0,          33};
        vecs[8]  = '{"remu_by_1",      2'b10, 32'hDEAD_BEEF,  32'd1,          32'd0,          33};
        vecs[9]  = '{"divu_by_0",      2'b01, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[10] = '{"remu_by_0",      2'b10, 32'h0000_1234,  32'd0,          32'h0000_1234,  1};
        vecs[11] = '{"op_reserved",    2'b11, 32'd5,          32'd3,          32'd0,          1};
        vecs[12] = '{"mul_big",        2'b00, 32'h0001_2345,  32'h0000_0100,  32'h0123_4500,  33};

        #12;
        chk("reset_busy",      {31'd0, busy},      32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_alu_req",   {31'd0, alu_req},   32'd0);
        chk("reset_rsp_data",  rsp_data,           32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0,
                   data, lat, grants, runcyc, saw_req, opbad, unstable);
            chk({vecs[i].name, "_data"},    data, vecs[i].exp);
            chk({vecs[i].name, "_latency"}, lat,  vecs[i].lat);
            chk({vecs[i].name, "_alu_req"}, {31'd0, saw_req}, (vecs[i].lat == 1) ? 32'd0 : 32'd1);
            chk({vecs[i].name, "_alu_op"},  {31'd0, opbad},   32'd0);
        end

        // Random grant with consumer stalling the response.
        run_op(2'b00, 32'd12345, 32'd678, 1'b1, 1'b1,
               data, lat, grants, runcyc, saw_req, opbad, unstable);
        chk("rnd_mul_data",     data,   32'd8369910);
        chk("rnd_mul_grants",   grants, 32);
        chk("rnd_mul_latency",  lat,    runcyc + 1);
        chk("rnd_mul_stable",   {31'd0, unstable}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_rsp_data",  rsp_data, 32'd8369910);
            chk("hold_flags",     {29'd0, rsp_valid, req_ready, busy}, 32'b101);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_release_idle", {30'd0, req_ready, busy}, 32'b10);

        // Abort a division part-way with an asynchronous reset.
        req_valid = 1'b1; req_op = 2'b01; req_a = 32'd1000; req_b = 32'd10; alu_grant = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cnt10 = 0;
        for (int i = 0; i < 50 && cnt10 < 10; i++) begin
            @(negedge clk);
            if (alu_req && alu_grant) cnt10++;
        end
        chk("abort_ten_grants", cnt10, 10);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy",      {31'd0, busy},      32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_alu_req",   {31'd0, alu_req},   32'd0);
        chk("abort_alu_a",     alu_a,              32'd0);
        chk("abort_rsp_data",  rsp_data,           32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_rsp", {30'd0, rsp_valid, req_ready}, 32'b01);

        run_op(2'b01, 32'd1000, 32'd10, 1'b0, 1'b0,
               data, lat, grants, runcyc, saw_req, opbad, unstable);
        chk("post_reset_divu", data, 32'd100);
        chk("post_reset_lat",  lat,  33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Iterative 32-bit MUL/DIVU/REMU sequencer for the EX stage. It has no adder of its own: each iteration borrows the shared EX-stage ALU through a per-cycle grant from the pipeline. Shifts and bookkeeping are internal to the block. Requests and responses use valid/ready handshakes, and the block processes one operation at a time.

Parameters:
XLEN, 32, operand/result width; the ALU interface is fixed at 32 bits.
CNT_W, 5, iteration counter width; iterations per operation = 2**CNT_W = XLEN.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept; high only in IDLE
req_op  input  2  00 MUL (low 32 bits), 01 DIVU, 10 REMU, 11 reserved
req_a  input  32  multiplicand / dividend
req_b  input  32  multiplier / divisor
alu_req  output  1  block wants the ALU this cycle; equals (state==RUN)
alu_grant  input  1  pipeline grants the ALU this cycle; ignored unless alu_req=1
alu_a  output  32  ALU operand A; 0 when not RUN
alu_b  output  32  ALU operand B; 0 when not RUN
alu_op  output  3  ALU opcode; 000 ADD for MUL, 001 SUB for DIV/REM; 000 when not RUN
alu_result  input  32  ALU result, combinational from alu_a/alu_b/alu_op
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_data  output  32  result; stable while rsp_valid=1
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, and all internal registers clear (acc, rem, mcand, mplier, quo, cnt, op). Outputs: req_ready=1 after release, rsp_valid=0, rsp_data=0, busy=0, alu_req=0.
- Reset mid-operation aborts the operation. No response is produced.
- FSM states are IDLE, RUN and DONE.
- IDLE: an accept is req_valid&req_ready at the clock edge. On accept, latch op, a and b.
  - Normal ops go to RUN with cnt=0.
  - DIVU with b==0: rsp_data=0xFFFFFFFF.
  - REMU with b==0: rsp_data=a.
  - op 11: rsp_data=0.
  - These three cases skip RUN and go straight to DONE, so rsp_valid is high the cycle after accept.
- RUN: alu_req=1. An iteration commits only on an edge where alu_grant=1. With alu_grant=0, all registers hold and alu_a/alu_b stay stable.
  - After the 32nd committed iteration (cnt==31 with grant), go to DONE.
  - rsp_data takes acc for MUL, quo for DIVU and rem for REMU.
- MUL iteration:
  - alu_a=acc; alu_b = mplier[0] ? mcand : 0; alu_op=ADD.
  - On grant: acc<=alu_result, mcand<=mcand<<1, mplier<=mplier>>1, cnt++.
  - Initial values: acc=0, mcand=a, mplier=b. Overflow bits beyond 32 are discarded.
- DIVU/REMU iteration (restoring division):
  - rs={rem[30:0],quo[31]}; top=rem[31].
  - alu_a=rs, alu_b=divisor, alu_op=SUB.
  - borrow=(~rs[31]&d[31]) | (~(rs[31]^d[31]) & alu_result[31]).
  - ok = top | ~borrow.
  - On grant: rem <= ok ? alu_result : rs; quo <= {quo[30:0],ok}; cnt++.
  - Initial values: rem=0, quo=a.
- DONE: rsp_valid=1 and req_ready=0. rsp_data is held until rsp_valid&rsp_ready at an edge, which returns the block to IDLE. A new request can be accepted in the cycle after the handshake, not in the same cycle.
- Latency with grant held high: accept at edge T, rsp_valid visible after edge T+32, i.e. 33 cycles from the accept cycle. In general, latency is 1 + (number of RUN cycles until 32 grants have occurred).
- Iteration count is fixed at 32 regardless of operand values (no early exit).

Decomposition:
- Package alu_pkg holds:
  - ALU opcode constants ALU_ADD=3'b000 and ALU_SUB=3'b001, shared with the existing ALU decode.
  - muldiv op constants MD_MUL=2'b00, MD_DIVU=2'b01, MD_REMU=2'b10.
  - FSM state enum {S_IDLE, S_RUN, S_DONE}.
- One natural sub-module: muldiv_step (combinational). It takes op and registers plus alu_result and produces the alu_a/alu_b/alu_op selection, ok/borrow, and the next-register values. The FSM and registers stay in alu_muldiv_seq.

Test Plan:
1. MUL a=7, b=6, grant tied 1, rsp_ready=1 -> rsp_data=42; rsp_valid rises exactly 33 cycles after the accept cycle; alu_op=000 throughout RUN.
2. MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MUL 0x00010000*0x00010000 -> 0x00000000.
3. DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0xFFFFFFFF/0x80000000 -> 1; REMU 0xFFFFFFFF/0x80000000 -> 0x7FFFFFFF (covers the top-bit/borrow path).
4. DIVU 0x1234/0 -> 0xFFFFFFFF and REMU 0x1234/0 -> 0x1234, each with rsp_valid one cycle after accept and alu_req never high; op=11 -> 0 in one cycle.
5. alu_grant random at 50% duty, MUL 12345*678 -> 8369910; exactly 32 granted RUN cycles; alu_a/alu_b stable across ungranted cycles. Then hold rsp_ready=0 for 5 cycles -> rsp_data stable, req_ready=0, busy=1.
6. rst_n pulled low after 10 committed iterations of DIVU -> outputs at reset values immediately (async), no rsp_valid; after release, DIVU 1000/10 -> 100.
